// File: rtl/imem_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader_pkg
//  Description : Shared state encodings and framing constants for the
//                instruction-memory boot loader.
//  Revision    : 1.0 - initial release
// ============================================================================
package imem_loader_pkg;

    // Loader FSM states
    typedef enum logic [1:0] {
        S_LEN_HI = 2'd0,
        S_LEN_LO = 2'd1,
        S_DATA   = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    // Header is a big-endian 16-bit word count
    localparam int HDR_BYTES      = 2;
    localparam int BYTES_PER_WORD = 4;
    localparam int INSTR_W        = 32;

    // Width of the byte-within-word counter
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

endpackage : imem_loader_pkg
`default_nettype wire

// File: rtl/imem_loader_byte_packer.sv
`default_nettype none
// ============================================================================
//  Module      : byte_packer
//  Description : Packs a byte stream big-endian into instruction words.
//                The first byte of a word ends up in the top byte lane.
//  Revision    : 1.0 - initial release
// ============================================================================
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               clear,
    input  logic               shift_en,
    input  logic [7:0]         byte_in,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);

    localparam logic [BYTE_CNT_W-1:0] c_LAST = BYTE_CNT_W'(BYTES_PER_WORD - 1);

    // Only the first three bytes need storage; the fourth is taken straight
    // from the input so the word is available on the same cycle.
    logic [BYTE_CNT_W-1:0] r_cnt;
    logic [INSTR_W-9:0]    r_shift;

    // Byte counter and shift register; counter wraps naturally every word
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            r_cnt   <= '0;
            r_shift <= '0;
        end else if (shift_en) begin
            r_cnt   <= r_cnt + BYTE_CNT_W'(1);
            r_shift <= {r_shift[INSTR_W-17:0], byte_in};
        end
    end

    assign word_valid = shift_en && (r_cnt == c_LAST);
    assign word       = {r_shift, byte_in};

endmodule : byte_packer
`default_nettype wire

// File: rtl/imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : imem_loader
//  Description : Boot-time instruction-memory writer. Receives a 16-bit word
//                count followed by the instruction bytes, writes the words to
//                consecutive addresses from 0 and holds the CPU in reset
//                until the image is complete.
//  Revision    : 1.0 - initial release
// ============================================================================
module imem_loader
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 5
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    input  logic               start,
    output logic               imem_we,
    output logic [ADDR_W-1:0]  imem_addr,
    output logic [INSTR_W-1:0] imem_d,
    output logic               cpu_rst_n,
    output logic               load_done,
    output logic               overflow
);

    localparam int c_CNT_W = HDR_BYTES * 8;
    // Depth held one bit wider than the index so it is representable even
    // when the memory spans the whole index range.
    localparam logic [c_CNT_W:0] c_DEPTH = (c_CNT_W + 1)'(2 ** ADDR_W);

    state_t               r_state;
    state_t               w_next;

    logic [c_CNT_W-1:0]   r_count;
    logic [c_CNT_W-1:0]   r_index;
    logic                 r_we;
    logic [ADDR_W-1:0]    r_addr;
    logic [INSTR_W-1:0]   r_d;
    logic                 r_cpu_rst_n;
    logic                 r_overflow;

    logic                 w_fire;
    logic                 w_start;
    logic                 w_last;
    logic                 w_in_range;
    logic                 w_word_valid;
    logic [INSTR_W-1:0]   w_word;

    assign in_ready   = (r_state != S_DONE);
    assign w_fire     = in_valid && in_ready;
    assign w_start    = start && (r_state == S_DONE);
    assign w_last     = ((r_index + c_CNT_W'(1)) == r_count);
    assign w_in_range = ({1'b0, r_index} < c_DEPTH);

    byte_packer u_packer (
        .clk        (clk),
        .rst_n      (rst_n),
        .clear      (w_start),
        .shift_en   (w_fire && (r_state == S_DATA)),
        .byte_in    (in_data),
        .word_valid (w_word_valid),
        .word       (w_word)
    );

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_LEN_HI;
        end else begin
            r_state <= w_next;
        end
    end

    // FSM next-state: header bytes, data words, then park until restarted
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_LEN_HI: begin
                if (w_fire) w_next = S_LEN_LO;
            end
            S_LEN_LO: begin
                if (w_fire) begin
                    if ({r_count[c_CNT_W-1 -: 8], in_data} == '0) w_next = S_DONE;
                    else                                        w_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_word_valid && w_last) w_next = S_DONE;
            end
            S_DONE: begin
                if (start) w_next = S_LEN_HI;
            end
            default: w_next = S_LEN_HI;
        endcase
    end

    // Datapath: word count, word index, write port and CPU reset release
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count     <= '0;
            r_index     <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_d         <= '0;
            r_cpu_rst_n <= 1'b0;
            r_overflow  <= 1'b0;
        end else begin
            r_we        <= 1'b0;
            // Released one cycle after entering S_DONE; dropped together
            // with the transition out of it.
            r_cpu_rst_n <= (r_state == S_DONE) && (w_next == S_DONE);

            if (w_start) begin
                r_overflow <= 1'b0;
                r_index    <= '0;
                r_count    <= '0;
            end

            if (w_fire && (r_state == S_LEN_HI)) begin
                r_count[c_CNT_W-1 -: 8] <= in_data;
            end

            if (w_fire && (r_state == S_LEN_LO)) begin
                r_count[7:0] <= in_data;
                r_index      <= '0;
            end

            if (w_word_valid) begin
                if (w_in_range) begin
                    r_we   <= 1'b1;
                    r_d    <= w_word;
                    r_addr <= r_index[ADDR_W-1:0];
                end else begin
                    r_overflow <= 1'b1;
                end
                r_index <= r_index + c_CNT_W'(1);
            end
        end
    end

    assign imem_we   = r_we;
    assign imem_addr = r_addr;
    assign imem_d    = r_d;
    assign cpu_rst_n = r_cpu_rst_n;
    assign load_done = r_cpu_rst_n;
    assign overflow  = r_overflow;

endmodule : imem_loader
`default_nettype wire

// File: tb/tb_imem_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_imem_loader
//  Description : Randomised scoreboard bench for imem_loader.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_imem_loader;

    localparam int ADDR_W = 5;
    localparam int DEPTH  = 2 ** ADDR_W;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              in_ready;
    logic              start = 1'b0;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_d;
    logic              cpu_rst_n;
    logic              load_done;
    logic              overflow;

    int checks = 0;
    int errors = 0;

    // Expected writes: {addr, data}
    logic [ADDR_W+31:0] exp_q[$];
    logic [ADDR_W+31:0] exp_e;
    logic [31:0]        img[$];

    imem_loader #(.ADDR_W(ADDR_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .start     (start),
        .imem_we   (imem_we),
        .imem_addr (imem_addr),
        .imem_d    (imem_d),
        .cpu_rst_n (cpu_rst_n),
        .load_done (load_done),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every write the DUT issues must match the head of the queue
    always @(negedge clk) begin
        if (imem_we === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr %0d data 0x%08h, expected no write",
                         imem_addr, imem_d);
            end else begin
                exp_e = exp_q.pop_front();
                check("write_addr", 32'(imem_addr), 32'(exp_e[ADDR_W+31:32]));
                check("write_data", imem_d, exp_e[31:0]);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Offer one byte after `gap` idle cycles; returns just after the accepting edge
    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        int t;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_valid = 1'b1;
        in_data  = b;
        t = 0;
        forever begin
            @(negedge clk);
            ok = in_ready;
            tick();
            if (ok) break;
            t++;
            if (t > 50) begin
                checks++;
                errors++;
                $display("FAIL byte_timeout: in_ready stayed 0, expected 1");
                break;
            end
        end
        in_valid = 1'b0;
    endtask

    function automatic int pick_gap(input int mode);
        if (mode == 1) return 1 + int'($urandom_range(3, 0));
        if (mode == 2) return int'($urandom_range(1, 0));
        return 0;
    endfunction

    // Send header + img[0..n-1]; words below DEPTH are expected as writes.
    // start_at >= 0 pulses start just before that data-byte position.
    task automatic load(input int n, input int mode, input int start_at);
        logic [15:0] nn;
        int pos;
        nn  = 16'(n);
        pos = 0;
        send_byte(nn[15:8], pick_gap(mode));
        send_byte(nn[7:0], pick_gap(mode));
        for (int i = 0; i < n; i++) begin
            for (int k = 0; k < 4; k++) begin
                if (pos == start_at) begin
                    start = 1'b1;
                    tick();
                    start = 1'b0;
                    check("start_ignored_ready", 32'(in_ready), 32'd1);
                    check("start_ignored_cpurst", 32'(cpu_rst_n), 32'd0);
                end
                send_byte(img[i][31-8*k -: 8], pick_gap(mode));
                pos++;
            end
            if (i < DEPTH) exp_q.push_back({i[ADDR_W-1:0], img[i]});
        end
    endtask

    task automatic check_reset_values();
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_imem_we", 32'(imem_we), 32'd0);
        check("rst_imem_addr", 32'(imem_addr), 32'd0);
        check("rst_imem_d", imem_d, 32'd0);
        check("rst_cpu_rst_n", 32'(cpu_rst_n), 32'd0);
        check("rst_load_done", 32'(load_done), 32'd0);
        check("rst_overflow", 32'(overflow), 32'd0);
    endtask

    task automatic do_reset();
        in_valid = 1'b0;
        start    = 1'b0;
        rst_n    = 1'b0;
        tick();
        rst_n    = 1'b1;
        check_reset_values();
    endtask

    // Right after the final accepted byte: parked, CPU still held, released next cycle
    task automatic check_finish(input string tag, input logic exp_ovf);
        check({tag, "_ready_low"}, 32'(in_ready), 32'd0);
        check({tag, "_cpurst_held"}, 32'(cpu_rst_n), 32'd0);
        tick();
        check({tag, "_cpurst_released"}, 32'(cpu_rst_n), 32'd1);
        check({tag, "_load_done"}, 32'(load_done), 32'd1);
        check({tag, "_overflow"}, 32'(overflow), 32'(exp_ovf));
        repeat (2) tick();
        check({tag, "_no_pending"}, 32'(exp_q.size()), 32'd0);
    endtask

    task automatic set_test1_image();
        img.delete();
        img.push_back(32'h20080005);
        img.push_back(32'hAC080004);
    endtask

    initial begin
        #600000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) tick();

        // 1: fixed two-word image, in_valid held high
        do_reset();
        set_test1_image();
        load(2, 0, -1);
        check_finish("t1", 1'b0);

        // 2: empty image
        do_reset();
        img.delete();
        load(0, 0, -1);
        check_finish("t2", 1'b0);

        // 3: same image with sparse valid and random gaps
        do_reset();
        set_test1_image();
        load(2, 1, -1);
        check_finish("t3", 1'b0);

        // 4: one word past the memory depth
        do_reset();
        img.delete();
        for (int i = 0; i < DEPTH + 1; i++) img.push_back($urandom);
        load(DEPTH + 1, 2, -1);
        check_finish("t4", 1'b1);

        // 6a: restart from S_DONE clears overflow and re-holds the CPU
        start = 1'b1;
        tick();
        start = 1'b0;
        check("restart_cpurst", 32'(cpu_rst_n), 32'd0);
        check("restart_load_done", 32'(load_done), 32'd0);
        check("restart_ready", 32'(in_ready), 32'd1);
        check("restart_overflow", 32'(overflow), 32'd0);

        // 6b: new image overwrites addr0; start mid-data is ignored
        img.delete();
        for (int i = 0; i < 3; i++) img.push_back($urandom);
        load(3, 2, 6);
        check_finish("t6", 1'b0);

        // 5: reset after five bytes discards the partial load
        do_reset();
        set_test1_image();
        send_byte(8'h00, 0);
        send_byte(8'h02, 0);
        send_byte(8'h20, 0);
        send_byte(8'h08, 0);
        send_byte(8'h00, 0);
        do_reset();
        check("t5_no_pending", 32'(exp_q.size()), 32'd0);
        load(2, 0, -1);
        check_finish("t5", 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_imem_loader
`default_nettype wire
